// File: rtl/dbus_test_monitor_if.sv
// dbus_test_monitor_if
//   Groups the snooped data-bus write channel and the log drain port of
//   dbus_test_monitor.
//   slave  : the monitor. It sees the bus write, drives the log head and
//            receives log_ready_i.
//   master : the environment. It drives the bus write and the consumer ready,
//            and sees the log head.
//   ADDR_W and DATA_W must match the parameters of the monitor instance.
interface dbus_test_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_we_i;
    logic [ADDR_W-1:0] bus_addr_i;
    logic [DATA_W-1:0] bus_wdata_i;
    logic              log_valid_o;
    logic              log_tag_o;
    logic [DATA_W-1:0] log_data_o;
    logic              log_ready_i;

    modport master (
        output bus_we_i, bus_addr_i, bus_wdata_i, log_ready_i,
        input  log_valid_o, log_tag_o, log_data_o
    );

    modport slave (
        input  bus_we_i, bus_addr_i, bus_wdata_i, log_ready_i,
        output log_valid_o, log_tag_o, log_data_o
    );
endinterface

// File: rtl/dbus_test_monitor.sv
// dbus_test_monitor
//   Snoops the core data-bus write channel. Signature and console writes are
//   queued into a tagged show-ahead FIFO. The FIFO is drained over a
//   valid/ready port. A halt write latches the exit code. An optional cycle
//   limit ends the run. Once the FIFO has drained, the block reports
//   done/pass/fail.
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   max_cycles_i    timeout limit (0 = no timeout)
//   bus             dbus_test_monitor_if.slave: bus write in, log head out
//   done_o          run finished and log drained (sticky)
//   pass_o          !timeout & !overflow & exit_code==0, qualified by done_o
//   timeout_o       the cycle limit ended the run (sticky)
//   overflow_o      at least one log push was dropped (sticky)
//   exit_code_o     data latched from the halt write
//   cycle_count_o   cycles spent in RUN (saturating)
module dbus_test_monitor #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] SIG_ADDR   = 32'h001FFE68,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = 32'h001FFE6C,
    parameter logic [ADDR_W-1:0] CON_ADDR   = 32'h001FFE70,
    parameter int                FIFO_DEPTH = 16,
    parameter int                CYC_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CYC_W-1:0]     max_cycles_i,
    dbus_test_monitor_if.slave   bus,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic                 overflow_o,
    output logic [DATA_W-1:0]    exit_code_o,
    output logic [CYC_W-1:0]     cycle_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Each FIFO entry holds {tag, data}. Pointers carry one extra wrap bit,
    // which tells a full FIFO apart from an empty one.
    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic [CYC_W-1:0]  cyc_q;
    logic              timeout_q, overflow_q;
    logic [DATA_W-1:0] exit_q;

    logic              fifo_empty, fifo_full, pop;
    logic              hit_sig, hit_con, hit_halt, tmo_hit;
    logic              push_req, push_ok;
    logic [DATA_W:0]   push_word;
    logic [DATA_W-1:0] con_data;
    logic              halt_take, tmo_take, cnt_inc;
    logic [DATA_W:0]   head;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop        = !fifo_empty && bus.log_ready_i;

    assign hit_sig  = bus.bus_we_i && (bus.bus_addr_i == SIG_ADDR);
    assign hit_con  = bus.bus_we_i && (bus.bus_addr_i == CON_ADDR);
    assign hit_halt = bus.bus_we_i && (bus.bus_addr_i == HALT_ADDR);
    assign tmo_hit  = (max_cycles_i != '0) && (cyc_q == max_cycles_i);

    // A console entry carries only the low byte, zero-extended.
    always_comb begin
        con_data      = '0;
        con_data[7:0] = bus.bus_wdata_i[7:0];
    end

    // Next state and per-cycle actions. The halt is checked before the
    // timeout, so a halt in the timeout cycle wins.
    always_comb begin
        state_d   = state_q;
        push_req  = 1'b0;
        push_word = '0;
        halt_take = 1'b0;
        tmo_take  = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hit_halt) begin
                    halt_take = 1'b1;
                    cnt_inc   = 1'b1;
                    state_d   = S_DRAIN;
                end else if (tmo_hit) begin
                    // Hold the counter so that it reads exactly the limit.
                    tmo_take = 1'b1;
                    state_d  = S_DRAIN;
                end else begin
                    cnt_inc = 1'b1;
                    if (hit_sig) begin
                        push_req  = 1'b1;
                        push_word = {1'b0, bus.bus_wdata_i};
                    end else if (hit_con) begin
                        push_req  = 1'b1;
                        push_word = {1'b1, con_data};
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) state_d = S_DONE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
    end

    // When the FIFO is full, a pop in the same cycle frees the slot that the
    // push is about to take.
    assign push_ok = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cyc_q      <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            exit_q     <= '0;
        end else begin
            state_q <= state_d;
            if (push_ok)                    wptr_q     <= wptr_q + 1'b1;
            if (pop)                        rptr_q     <= rptr_q + 1'b1;
            if (push_req && !push_ok)       overflow_q <= 1'b1;
            if (cnt_inc && (cyc_q != '1))   cyc_q      <= cyc_q + 1'b1;
            if (tmo_take)                   timeout_q  <= 1'b1;
            if (halt_take)                  exit_q     <= bus.bus_wdata_i;
        end
    end

    // Storage has no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= push_word;
    end

    // The head is forced to zero while the FIFO is empty, so that stale
    // storage never appears on the port (including just after reset).
    assign head            = mem[rptr_q[AW-1:0]];
    assign bus.log_valid_o = !fifo_empty;
    assign bus.log_tag_o   = !fifo_empty && head[DATA_W];
    assign bus.log_data_o  = fifo_empty ? '0 : head[DATA_W-1:0];

    assign done_o        = (state_q == S_DONE);
    assign pass_o        = done_o && !timeout_q && !overflow_q && (exit_q == '0);
    assign timeout_o     = timeout_q;
    assign overflow_o    = overflow_q;
    assign exit_code_o   = exit_q;
    assign cycle_count_o = cyc_q;

endmodule

// File: tb/tb_dbus_test_monitor.sv
module tb_dbus_test_monitor;

    localparam logic [31:0] SIG  = 32'h001FFE68;
    localparam logic [31:0] HALT = 32'h001FFE6C;
    localparam logic [31:0] CON  = 32'h001FFE70;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] max_cycles;
    logic        done, pass, tmo, ovf;
    logic [31:0] exit_code, cyc;
    int          checks = 0;
    int          errors = 0;

    dbus_test_monitor_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    dbus_test_monitor #(.FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .max_cycles_i (max_cycles),
        .bus          (bif),
        .done_o       (done),
        .pass_o       (pass),
        .timeout_o    (tmo),
        .overflow_o   (ovf),
        .exit_code_o  (exit_code),
        .cycle_count_o(cyc)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bif.bus_we_i    = 1'b1;
        bif.bus_addr_i  = a;
        bif.bus_wdata_i = d;
        tick();
        bif.bus_we_i    = 1'b0;
        bif.bus_addr_i  = '0;
        bif.bus_wdata_i = '0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({bif.log_valid_o, bif.log_tag_o, bif.log_data_o, done, pass, tmo, ovf, exit_code, cyc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b t=%b d=%h done=%b pass=%b tmo=%b ovf=%b exit=%h cyc=%0d, want all zero",
                     bif.log_valid_o, bif.log_tag_o, bif.log_data_o, done, pass, tmo, ovf, exit_code, cyc);
        end
    endtask

    task automatic test_signature;
        do_reset();
        bif.log_ready_i = 1'b1;
        bus_write(SIG, 32'hDEADBEEF);
        checks++;
        if ({bif.log_valid_o, bif.log_tag_o, bif.log_data_o} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL sig_first: got v=%b t=%b d=%h, want 1 0 deadbeef", bif.log_valid_o, bif.log_tag_o, bif.log_data_o);
        end
        bus_write(SIG, 32'h12345678);
        checks++;
        if ({bif.log_valid_o, bif.log_tag_o, bif.log_data_o} !== {2'b10, 32'h12345678}) begin
            errors++;
            $display("FAIL sig_second: got v=%b t=%b d=%h, want 1 0 12345678", bif.log_valid_o, bif.log_tag_o, bif.log_data_o);
        end
        bus_write(HALT, 32'h0);
        checks++;
        if ({bif.log_valid_o, done} !== 2'b00) begin
            errors++;
            $display("FAIL sig_drain: got valid=%b done=%b, want 0 0", bif.log_valid_o, done);
        end
        tick();
        checks++;
        if ({done, pass, exit_code} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL sig_done: got done=%b pass=%b exit=%h, want 1 1 0", done, pass, exit_code);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        bif.log_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) bus_write(SIG, 32'h100 + i);
        bus_write(HALT, 32'h0);
        checks++;
        if ({ovf, bif.log_valid_o, done} !== 3'b110) begin
            errors++;
            $display("FAIL ovf_flag: got ovf=%b valid=%b done=%b, want 1 1 0", ovf, bif.log_valid_o, done);
        end
        bif.log_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bif.log_valid_o, bif.log_data_o} !== {1'b1, 32'h100 + i}) begin
                errors++;
                $display("FAIL ovf_entry%0d: got v=%b d=%h, want 1 %h", i, bif.log_valid_o, bif.log_data_o, 32'h100 + i);
            end
            tick();
        end
        checks++;
        if (bif.log_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: got valid=%b, want 0", bif.log_valid_o);
        end
        tick();
        checks++;
        if ({done, pass} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_done: got done=%b pass=%b, want 1 0", done, pass);
        end
    endtask

    task automatic test_timeout;
        int n;
        do_reset();
        bif.log_ready_i = 1'b0;
        max_cycles = 32'd100;
        n = 0;
        while (!tmo && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if ({tmo, cyc} !== {1'b1, 32'd100}) begin
            errors++;
            $display("FAIL tmo_count: got timeout=%b cycles=%0d after %0d ticks, want 1 100", tmo, cyc, n);
        end
        bus_write(SIG, 32'hCAFE);
        tick();
        checks++;
        if ({done, pass, bif.log_valid_o, cyc} !== {3'b100, 32'd100}) begin
            errors++;
            $display("FAIL tmo_done: got done=%b pass=%b valid=%b cyc=%0d, want 1 0 0 100", done, pass, bif.log_valid_o, cyc);
        end
        max_cycles = '0;
    endtask

    task automatic test_console;
        logic [32:0] exp [3];
        exp[0] = {1'b1, 32'h41};
        exp[1] = {1'b0, 32'hA5};
        exp[2] = {1'b1, 32'h42};
        do_reset();
        bif.log_ready_i = 1'b0;
        bus_write(CON, 32'h12345641);
        bus_write(SIG, 32'h000000A5);
        bus_write(CON, 32'h00000042);
        bif.log_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bif.log_valid_o, bif.log_tag_o, bif.log_data_o} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL con_entry%0d: got v=%b t=%b d=%h, want 1 %b %h", i, bif.log_valid_o, bif.log_tag_o,
                         bif.log_data_o, exp[i][32], exp[i][31:0]);
            end
            tick();
        end
    endtask

    task automatic test_collision;
        // Halt lands in the cycle where cycle_count equals the limit.
        do_reset();
        bif.log_ready_i = 1'b1;
        max_cycles = 32'd5;
        for (int i = 0; i < 5; i++) tick();
        bus_write(HALT, 32'd3);
        tick();
        checks++;
        if ({done, tmo, pass, exit_code} !== {3'b100, 32'd3}) begin
            errors++;
            $display("FAIL collide_halt_tmo: got done=%b tmo=%b pass=%b exit=%0d, want 1 0 0 3", done, tmo, pass, exit_code);
        end
        max_cycles = '0;
        // Full FIFO: a push and a pop in the same cycle.
        do_reset();
        bif.log_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) bus_write(SIG, 32'h200 + i);
        bif.log_ready_i = 1'b1;
        bus_write(SIG, 32'h2FF);
        checks++;
        if ({ovf, bif.log_data_o} !== {1'b0, 32'h201}) begin
            errors++;
            $display("FAIL collide_full: got ovf=%b head=%h, want 0 201", ovf, bif.log_data_o);
        end
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if ({bif.log_valid_o, bif.log_data_o} !== {1'b1, 32'h2FF}) begin
            errors++;
            $display("FAIL collide_last: got v=%b d=%h, want 1 2ff", bif.log_valid_o, bif.log_data_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain;
        do_reset();
        bif.log_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(SIG, 32'h300 + i);
        bus_write(HALT, 32'd7);
        reset = 1'b1;
        tick();
        checks++;
        if ({bif.log_valid_o, bif.log_tag_o, bif.log_data_o, done, pass, tmo, ovf, exit_code, cyc} !== '0) begin
            errors++;
            $display("FAIL rst_drain_zero: got v=%b d=%h done=%b exit=%h cyc=%0d, want all zero",
                     bif.log_valid_o, bif.log_data_o, done, exit_code, cyc);
        end
        reset = 1'b0;
        bus_write(SIG, 32'h77);
        checks++;
        if ({bif.log_valid_o, bif.log_tag_o, bif.log_data_o, done} !== {2'b10, 32'h77, 1'b0}) begin
            errors++;
            $display("FAIL rst_drain_new: got v=%b t=%b d=%h done=%b, want 1 0 77 0",
                     bif.log_valid_o, bif.log_tag_o, bif.log_data_o, done);
        end
    endtask

    initial begin
        reset           = 1'b1;
        max_cycles      = '0;
        bif.bus_we_i    = 1'b0;
        bif.bus_addr_i  = '0;
        bif.bus_wdata_i = '0;
        bif.log_ready_i = 1'b0;
        test_reset();
        test_signature();
        test_overflow();
        test_timeout();
        test_console();
        test_collision();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_test_monitor.md
# dbus_test_monitor

Synthesizable test-host monitor that snoops the core data-bus write channel inside `soc_top`, enabling simulation benches and FPGA self-test builds to share one completion mechanism. It captures signature and console writes into a tagged FIFO drained over a valid/ready port. It latches a halt/exit code, enforces a programmable cycle timeout, and reports done/pass/fail once all captured data has drained. This generalises the bench-only signature/halt/timeout logic into a parametrised, buffered block with console support and back-pressure.

## Interface

Parameters:
- `ADDR_W`, 32: bus address width.
- `DATA_W`, 32: bus write-data width; ≥ 8.
- `SIG_ADDR`, 32'h001FFE68: signature write address.
- `HALT_ADDR`, 32'h001FFE6C: halt/exit-code write address.
- `CON_ADDR`, 32'h001FFE70: console character write address.
- `FIFO_DEPTH`, 16: log FIFO entries; power of two, ≥ 2.
- `CYC_W`, 32: cycle counter and limit width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `max_cycles_i`  in  CYC_W  timeout limit; 0 disables the timeout; sampled every cycle.
- `bus_we_i`  in  1  write strobe; one qualified write per cycle.
- `bus_addr_i`  in  ADDR_W  write address.
- `bus_wdata_i`  in  DATA_W  write data.
- `log_valid_o`  out  1  FIFO head valid.
- `log_tag_o`  out  1  0 = signature word, 1 = console character.
- `log_data_o`  out  DATA_W  head data; console entries are zero-extended `wdata[7:0]`.
- `log_ready_i`  in  1  consumer accepts head.
- `done_o`  out  1  run finished and FIFO drained; sticky.
- `pass_o`  out  1  valid only while `done_o`=1.
- `timeout_o`  out  1  sticky; the timeout ended the run.
- `overflow_o`  out  1  sticky; at least one push was dropped.
- `exit_code_o`  out  DATA_W  latched halt data.
- `cycle_count_o`  out  CYC_W  cycles spent in RUN.

## Operation

- FSM states: RUN (reset state), DRAIN, DONE.
- RUN, each cycle:
  - `cycle_count` increments, saturating at all-ones.
  - A write to SIG_ADDR pushes {0, wdata}.
  - A write to CON_ADDR pushes {1, zero-extended wdata[7:0]}.
  - A write to HALT_ADDR latches `exit_code`, pushes nothing, and moves to DRAIN.
  - Writes to any other address are ignored.
- Timeout: in RUN, when `max_cycles_i` ≠ 0 and `cycle_count` == `max_cycles_i`, set `timeout_o` and move to DRAIN. That cycle's bus write is ignored.
- Halt and timeout in the same cycle: halt wins and `timeout_o` stays 0.
- DRAIN:
  - All bus writes are ignored and the counter holds.
  - When the FIFO is empty (`log_valid_o`=0), move to DONE.
- DONE:
  - `done_o`=1.
  - `pass_o` = !timeout & !overflow & (exit_code == 0).
  - DONE holds until `reset`; bus writes are ignored.
- FIFO:
  - Show-ahead; a pop happens when `log_valid_o` & `log_ready_i`.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the push is dropped and `overflow_o` is set.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- The log port is usable in every state; the consumer may stall it indefinitely.

## Timing

- Reset, registered on the `clk` edge while `reset`=1:
  - FSM enters RUN and the FIFO empties.
  - All outputs are 0: `log_valid_o`, `log_tag_o`, `log_data_o`, `done_o`, `pass_o`, `timeout_o`, `overflow_o`, `exit_code_o`, `cycle_count_o`.
- Reset mid-run or mid-drain discards FIFO contents without any pop handshake.
- Push-to-visibility latency is 1 cycle: a write in cycle N gives `log_valid_o`=1 in N+1 if the FIFO was empty.
- A popped head is replaced by the next entry in the following cycle; back-to-back pops give 1 entry per cycle.
- Halt in cycle N with an empty FIFO: DRAIN in N+1, `done_o`=1 in N+2.
- Timeout: with limit L, `timeout_o` rises after cycle L of RUN, i.e. the edge at which `cycle_count` == L is observed.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Signature dump:** write 0xDEADBEEF, 0x12345678 to SIG_ADDR, then 0 to HALT_ADDR, with `log_ready_i`=1.
  - Log shows two tag-0 entries in order.
  - `done_o`=1 two cycles after the last pop; `pass_o`=1 and `exit_code_o`=0.
- **Back-pressure and overflow:** hold `log_ready_i`=0 and issue 20 SIG writes with FIFO_DEPTH=16, then halt, then release ready.
  - First 16 values are drained in order; `overflow_o`=1.
  - `done_o`=1 and `pass_o`=0.
- **Timeout:** `max_cycles_i`=100 with no halt.
  - `timeout_o`=1 and `cycle_count_o`=100.
  - `done_o`=1 and `pass_o`=0; later SIG writes are not logged.
- **Console interleave:** CON write 0x1234_5641, SIG write 0xA5, CON write 0x42.
  - Log entries: (1,0x41), (0,0xA5), (1,0x42).
- **Edge collisions:**
  - Halt with code 3 in the same cycle as the timeout: `timeout_o`=0, `exit_code_o`=3, `pass_o`=0.
  - Full FIFO with simultaneous push and pop: the push is accepted and `overflow_o` stays 0.
- **Reset mid-drain:** assert `reset` for 1 cycle while 5 entries are queued.
  - All outputs read 0 next cycle and the FSM is in RUN.
  - A new SIG write appears 1 cycle later.
